counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Sequences the 8-bit up/down counter datapath on behalf of two requesters.
//  Accepts commands (CLEAR, LOAD, COUNT UP n, COUNT DOWN n) over valid/ready, round-robin between requesters.
//  Drives the counter's clear_n/load/up_down/in pins. Reports the final count on a one-cycle done pulse.
//  Holds the counter between commands by reloading its own output (the counter has no enable).
// PARAMETERS
//  WIDTH   8  counter data width; count wraps modulo 2**WIDTH
//  STEP_W  8  width of the step-count field for UP/DOWN commands
// PORTS
//  clk          in   1            clock; all logic on posedge
//  clear        in   1            synchronous, active-high reset
//  req_valid    in   2            per-requester command valid
//  req_ready    out  2            per-requester accept; one-hot or zero
//  req_op       in   2x2          {op1,op0}; 00 CLR, 01 LOAD, 10 UP, 11 DOWN
//  req_data     in   2xWIDTH      LOAD: value; UP/DOWN: step count (low STEP_W bits)
//  cnt_out      in   WIDTH        counter's current value
//  cnt_in       out  WIDTH        counter data input
//  cnt_load     out  1            counter load strobe
//  cnt_up_down  out  1            1 = count up, 0 = count down
//  cnt_clear_n  out  1            counter clear, active-low
//  done_valid   out  1            one-cycle completion pulse
//  done_id      out  1            requester that issued the completed command
//  done_value   out  WIDTH        cnt_out at completion
//  busy         out  1            state != IDLE
// BEHAVIOUR
//  Reset (clear=1):
//   - state=IDLE, rr_ptr=0, remaining=0.
//   - cnt_clear_n=0, so the counter zeroes on the same edge.
//   - All other outputs 0: req_ready, done_*, busy, cnt_load, cnt_up_down, cnt_in.
//   - A command in flight when clear asserts is aborted; no done pulse is issued.
//  Outputs are decoded from registered state. cnt_clear_n=1 whenever clear=0 and the state is not a CLR execute.
//  IDLE:
//   - Hold: cnt_load=1, cnt_in=cnt_out.
//   - If any req_valid: req_ready=1 for the granted requester only.
//   - Grant: the sole valid requester; if both are valid, requester rr_ptr.
//   - On transfer (valid & ready): latch op, data, id; rr_ptr <= ~id; go to EXEC.
//  Handshake: a requester holds valid, op and data stable until ready. Ready is never asserted without valid.
//  EXEC, by latched op:
//   - CLR: cnt_clear_n=0 for 1 cycle -> DONE.
//   - LOAD: cnt_load=1, cnt_in=data for 1 cycle -> DONE.
//   - UP/DOWN, steps N = data[STEP_W-1:0]:
//     - N=0: hold for 1 cycle -> DONE.
//     - Otherwise cnt_load=0, cnt_up_down=(op==UP) for exactly N cycles; remaining counts down from N.
//     - Go to DONE on the cycle remaining==1.
//  DONE:
//   - Hold as in IDLE.
//   - done_valid=1, done_id=latched id, done_value=cnt_out (the counter has already taken the final edge).
//   - Next state IDLE. No new command is accepted in DONE.
//  Latency from accept to done_valid: CLR/LOAD 2 cycles; UP/DOWN N+1 cycles (N=0 -> 2 cycles).
//  Wrap-around: no saturation. The counter wraps (0xFF+1=0x00, 0x00-1=0xFF) and the sequencer ignores it.
//  Starvation: with both requesters continuously valid, grants strictly alternate.
// STRUCTURE
//  Package counter_seq_pkg:
//   - op encodings OP_CLR/OP_LOAD/OP_UP/OP_DOWN
//   - state enum {IDLE, EXEC, DONE}
//   - WIDTH/STEP_W defaults
//  Sub-module rr_arb2: 2-way round-robin arbiter (valid[1:0], ptr, advance -> grant one-hot).
// TESTING
//  1 Reset with cnt_out=0x37 -> cnt_clear_n=0, all other outputs 0; state IDLE after clear drops.
//  2 Req0 LOAD 0xFE, then Req0 UP 3 -> done_value 0xFE after the LOAD; UP done after 4 cycles with done_value=0x01 (wrap).
//  3 Req0 and Req1 both valid from reset (CLR, DOWN 2):
//    - req0 granted first and done at 0x00.
//    - req1 granted next; done_value=0xFE, done_id=1.
//  4 UP 0 from 0x10 -> done 2 cycles after accept; value 0x10; cnt_load held high throughout.
//  5 DOWN 5 from 0x08, clear asserted on the 3rd EXEC cycle -> no done_valid; next cycle IDLE, counter 0, rr_ptr=0.
//  6 Both requesters valid for 6 consecutive commands -> done_id sequence 0,1,0,1,0,1; req_ready never 2'b11.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared encodings and defaults for the counter sequencer.
package counter_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned STEP_W_DEF = 8;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/counter_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: ptr picks the winner only when both requesters are valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] grant
);

    // Grant is one-hot or zero, and never set for a requester that is not valid.
    always_comb begin
        grant = 2'b00;
        if (advance) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an external up/down counter (no enable) for two requesters.
// The counter is held between commands by reloading its own output.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0]   cnt_out,
    output logic [WIDTH-1:0]   cnt_in,
    output logic               cnt_load,
    output logic               cnt_up_down,
    output logic               cnt_clear_n,
    output logic               done_valid,
    output logic               done_id,
    output logic [WIDTH-1:0]   done_value,
    output logic               busy
);

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [STEP_W-1:0]  remaining_q, remaining_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               id_q, id_d;

    logic [1:0]         grant;
    logic               transfer;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_data;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .advance ((state_q == IDLE) && !clear),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);
    assign sel_op    = grant[1] ? req_op[3:2] : req_op[1:0];
    assign sel_data  = grant[1] ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];

    // Next-state and counter-pin decode from registered state; clear forces everything quiet.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        data_d      = data_q;
        id_d        = id_q;
        cnt_in      = '0;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b0;
        cnt_clear_n = 1'b1;
        done_valid  = 1'b0;
        done_id     = 1'b0;
        done_value  = '0;
        busy        = 1'b0;

        if (clear) begin
            cnt_clear_n = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_load = 1'b1;
                    cnt_in   = cnt_out;
                    if (transfer) begin
                        op_d        = sel_op;
                        data_d      = sel_data;
                        id_d        = grant[1];
                        rr_ptr_d    = ~grant[1];
                        remaining_d = sel_data[STEP_W-1:0];
                        state_d     = EXEC;
                    end
                end
                EXEC: begin
                    busy = 1'b1;
                    unique case (op_q)
                        OP_CLR: begin
                            cnt_clear_n = 1'b0;
                            state_d     = DONE;
                        end
                        OP_LOAD: begin
                            cnt_load = 1'b1;
                            cnt_in   = data_q;
                            state_d  = DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            if (remaining_q == '0) begin
                                // Zero-step command still takes one hold cycle.
                                cnt_load = 1'b1;
                                cnt_in   = cnt_out;
                                state_d  = DONE;
                            end else begin
                                cnt_up_down = (op_q == OP_UP);
                                remaining_d = remaining_q - STEP_W'(1);
                                if (remaining_q == STEP_W'(1)) begin
                                    state_d = DONE;
                                end
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
                DONE: begin
                    busy       = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_in     = cnt_out;
                    done_valid = 1'b1;
                    done_id    = id_q;
                    done_value = cnt_out;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous clear; clear aborts any command in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            remaining_q <= '0;
            op_q        <= OP_CLR;
            data_q      <= '0;
            id_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            data_q      <= data_d;
            id_q        <= id_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural model of the 8-bit counter.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       clear;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_op;
    logic [15:0] req_data;
    logic [7:0] cnt_out;
    logic [7:0] cnt_in;
    logic       cnt_load;
    logic       cnt_up_down;
    logic       cnt_clear_n;
    logic       done_valid;
    logic       done_id;
    logic [7:0] done_value;
    logic       busy;

    logic [7:0] cnt_model = 8'h37;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Counter under control: clear_n > load > count.
    always @(posedge clk) begin
        if (!cnt_clear_n)     cnt_model <= 8'h00;
        else if (cnt_load)    cnt_model <= cnt_in;
        else if (cnt_up_down) cnt_model <= cnt_model + 8'h01;
        else                  cnt_model <= cnt_model - 8'h01;
    end
    assign cnt_out = cnt_model;

    counter_sequencer dut (
        .clk         (clk),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .cnt_out     (cnt_out),
        .cnt_in      (cnt_in),
        .cnt_load    (cnt_load),
        .cnt_up_down (cnt_up_down),
        .cnt_clear_n (cnt_clear_n),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_value  (done_value),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the negedge of the accept cycle; counts edges until done_valid.
    task automatic run_to_done(input string tag, input logic [1:0] drop, input int exp_lat,
                               input logic exp_id, input logic [7:0] exp_val);
        int lat;
        lat = 0;
        tick();
        req_valid = req_valid & ~drop;
        @(negedge clk);
        lat++;
        while (!done_valid && lat < 20) begin
            tick();
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done_id"}, {31'd0, done_id}, {31'd0, exp_id});
        chk({tag, "_done_value"}, {24'd0, done_value}, {24'd0, exp_val});
    endtask

    // Single-requester command, entered at posedge+1 in IDLE and left there likewise.
    task automatic issue(input string tag, input logic id, input logic [1:0] op,
                         input logic [7:0] data, input int exp_lat, input logic [7:0] exp_val);
        if (id) begin
            req_op[3:2]    = op;
            req_data[15:8] = data;
            req_valid      = 2'b10;
        end else begin
            req_op[1:0]    = op;
            req_data[7:0]  = data;
            req_valid      = 2'b01;
        end
        @(negedge clk);
        chk({tag, "_ready"}, {30'd0, req_ready}, {30'd0, req_valid});
        run_to_done(tag, 2'b11, exp_lat, id, exp_val);
        tick();
    endtask

    initial begin
        logic       exp_id;
        logic [7:0] exp_val;

        clear     = 1'b1;
        req_valid = 2'b00;
        req_op    = 4'b0000;
        req_data  = 16'h0000;

        // 1: reset with the counter showing 0x37
        #2;
        chk("rst_cnt_out", {24'd0, cnt_out}, 32'h37);
        chk("rst_clear_n", {31'd0, cnt_clear_n}, 0);
        chk("rst_outputs", {req_ready, done_valid, done_id, done_value, busy, cnt_load,
                            cnt_up_down, cnt_in}, 0);
        tick();
        tick();
        chk("rst_counter_zeroed", {24'd0, cnt_out}, 0);
        clear = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_clear_n", {31'd0, cnt_clear_n}, 1);
        chk("idle_hold", {cnt_load, cnt_in}, {1'b1, 8'h00});
        chk("idle_ready", {30'd0, req_ready}, 0);
        tick();

        // 2: LOAD 0xFE then UP 3 wraps to 0x01
        issue("load_fe", 1'b0, 2'b01, 8'hFE, 2, 8'hFE);
        issue("up3_wrap", 1'b0, 2'b10, 8'h03, 4, 8'h01);

        // 3: both valid from reset: req0 CLR first, then req1 DOWN 2
        clear = 1'b1;
        tick();
        clear = 1'b0;
        req_op    = {2'b11, 2'b00};
        req_data  = {8'h02, 8'h55};
        req_valid = 2'b11;
        @(negedge clk);
        chk("both_first_grant", {30'd0, req_ready}, 32'h1);
        run_to_done("clr_req0", 2'b01, 2, 1'b0, 8'h00);
        chk("no_accept_in_done", {30'd0, req_ready}, 0);
        tick();
        @(negedge clk);
        chk("both_second_grant", {30'd0, req_ready}, 32'h2);
        run_to_done("down2_req1", 2'b10, 3, 1'b1, 8'hFE);
        tick();

        // 4: UP 0 from 0x10 holds the counter
        issue("load_10", 1'b0, 2'b01, 8'h10, 2, 8'h10);
        req_op[1:0]   = 2'b10;
        req_data[7:0] = 8'h00;
        req_valid     = 2'b01;
        @(negedge clk);
        chk("up0_ready", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("up0_exec_load", {cnt_load, cnt_in, busy}, {1'b1, 8'h10, 1'b1});
        chk("up0_exec_no_done", {31'd0, done_valid}, 0);
        tick();
        @(negedge clk);
        chk("up0_done", {done_valid, cnt_load, done_value}, {1'b1, 1'b1, 8'h10});
        tick();

        // 5: DOWN 5 aborted by clear on the 3rd EXEC cycle
        issue("load_08", 1'b1, 2'b01, 8'h08, 2, 8'h08);
        req_op[1:0]   = 2'b11;
        req_data[7:0] = 8'h05;
        req_valid     = 2'b01;
        @(negedge clk);
        chk("down5_ready", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        clear = 1'b1;
        @(negedge clk);
        chk("abort_cnt_mid", {24'd0, cnt_out}, 32'h06);
        chk("abort_outputs", {cnt_clear_n, busy, done_valid, cnt_load}, 0);
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("abort_after", {done_valid, busy, cnt_out}, 0);
        chk("abort_idle_hold", {31'd0, cnt_load}, 1);
        tick();

        // 6: six back-to-back LOADs from both requesters alternate grants
        req_op    = {2'b01, 2'b01};
        req_data  = {8'h80, 8'h40};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_id  = k[0];
            exp_val = exp_id ? req_data[15:8] : req_data[7:0];
            @(negedge clk);
            chk("alt_ready", {30'd0, req_ready}, exp_id ? 32'h2 : 32'h1);
            tick();
            if (exp_id) req_data[15:8] = req_data[15:8] + 8'h01;
            else        req_data[7:0]  = req_data[7:0] + 8'h01;
            @(negedge clk);
            chk("alt_exec_ready", {30'd0, req_ready}, 0);
            tick();
            @(negedge clk);
            chk("alt_done", {done_valid, done_id, done_value}, {1'b1, exp_id, exp_val});
            tick();
        end
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
